// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the arbiter state encoding and the transmitter acknowledge window.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB,
        ISSUE,
        WRITE,
        WAIT_ACK,
        WAIT_DONE
    } arb_state_t;

    // Cycles after the write strobe within which the transmitter must raise busy.
    localparam int unsigned ACK_WINDOW = 2;
    localparam int unsigned ACK_CNT_W  = 2;

    localparam logic [7:0] TX_DATA_RST = 8'hff;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of mask at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(ptr) + i) % N);
            if (!found && mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding bytes from NREQ requesters to one UART transmitter.
// Each byte is strobed once and the transmitter must go busy and idle again before the next.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned HOLD_TIMEOUT = 16
) (
    input  logic                      i_uart_clk,
    input  logic                      i_rst_n,
    input  logic [NREQ-1:0]           i_req_valid,
    input  logic [8*NREQ-1:0]         i_req_data,
    input  logic [NREQ-1:0]           i_req_last,
    output logic [NREQ-1:0]           o_req_ready,
    output logic                      o_tx_write,
    output logic [7:0]                o_tx_data,
    input  logic                      i_tx_busy,
    output logic [$clog2(NREQ)-1:0]   o_grant_id,
    output logic                      o_active,
    output logic                      o_err
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned HW = $clog2(HOLD_TIMEOUT + 1);

    arb_state_t           state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic                 active_q, active_d;
    logic                 write_q, write_d;
    logic [7:0]           data_q, data_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;
    logic [ACK_CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;

    logic [IW-1:0]        pick_idx;
    logic                 pick_found;
    logic                 sel_valid;
    logic                 sel_last;
    logic [7:0]           sel_data;
    logic                 accept;
    logic [IW-1:0]        next_ptr;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .mask  (i_req_valid),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Mux the granted requester's signals.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant_q == IW'(k)) begin
                sel_valid = i_req_valid[k];
                sel_last  = i_req_last[k];
                sel_data  = i_req_data[8*k +: 8];
            end
        end
    end

    assign accept   = (state_q == ISSUE) && sel_valid && !i_tx_busy;
    assign next_ptr = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);

    // Ready follows busy directly so a byte is never taken while the transmitter is occupied.
    assign o_req_ready = ((state_q == ISSUE) && !i_tx_busy) ? (NREQ'(1) << grant_q) : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        active_d   = active_q;
        write_d    = 1'b0;
        data_d     = data_q;
        last_d     = last_q;
        err_d      = err_q;
        ack_cnt_d  = ack_cnt_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            ARB: begin
                active_d   = 1'b0;
                hold_cnt_d = '0;
                if (pick_found) begin
                    grant_d  = pick_idx;
                    active_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    data_d     = sel_data;
                    last_d     = sel_last;
                    write_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = WRITE;
                end else if (!sel_valid) begin
                    // Stalled owner: release the grant once the idle budget is spent.
                    if (hold_cnt_q == HW'(HOLD_TIMEOUT - 1)) begin
                        hold_cnt_d = '0;
                        active_d   = 1'b0;
                        ptr_d      = next_ptr;
                        state_d    = ARB;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
            end
            WRITE: begin
                ack_cnt_d = '0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (i_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == ACK_CNT_W'(ACK_WINDOW - 1)) begin
                    err_d   = 1'b1;
                    state_d = WAIT_DONE;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    if (last_q) begin
                        active_d = 1'b0;
                        ptr_d    = next_ptr;
                        state_d  = ARB;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            grant_q    <= '0;
            active_q   <= 1'b0;
            write_q    <= 1'b0;
            data_q     <= TX_DATA_RST;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            ack_cnt_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            active_q   <= active_d;
            write_q    <= write_d;
            data_q     <= data_d;
            last_q     <= last_d;
            err_q      <= err_d;
            ack_cnt_q  <= ack_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign o_tx_write = write_q;
    assign o_tx_data  = data_q;
    assign o_grant_id = grant_q;
    assign o_active   = active_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural transmitter and a packet-level
// round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 16;

    logic                    clk;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [8*NREQ-1:0]       req_data;
    logic [NREQ-1:0]         req_last;
    logic [NREQ-1:0]         req_ready;
    logic                    tx_write;
    logic [7:0]              tx_data;
    logic                    tx_busy;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic                    active;
    logic                    err;

    int vecs;
    int miscmp;
    int cyc;

    logic [8:0] rq [NREQ][$];
    int         got_id[$];
    logic [7:0] got_byte[$];
    int         exp_id[$];
    logic [7:0] exp_byte[$];
    int         m_ptr;

    int         tx_left;
    bit         tx_dead;
    int         busy_min, busy_max;
    logic       s_write, s_active, s_err, s_busy;
    logic [7:0] prev_data;

    uart_tx_arbiter #(
        .NREQ         (NREQ),
        .HOLD_TIMEOUT (HOLD)
    ) dut (
        .i_uart_clk  (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_tx_write  (tx_write),
        .o_tx_data   (tx_data),
        .i_tx_busy   (tx_busy),
        .o_grant_id  (grant_id),
        .o_active    (active),
        .o_err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive_reqs();
        logic [8:0] b;
        for (int k = 0; k < NREQ; k++) begin
            if (rq[k].size() > 0) begin
                b = rq[k][0];
                req_valid[k] = 1'b1;
                req_data[8*k +: 8] = b[7:0];
                req_last[k] = b[8];
            end else begin
                req_valid[k] = 1'b0;
                req_last[k] = 1'b0;
            end
        end
    endtask

    // One clock: observe at negedge, then update requesters and transmitter after posedge.
    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        cyc++;
        s_write  = tx_write;
        s_active = active;
        s_err    = err;
        s_busy   = tx_busy;
        acc      = req_valid & req_ready;
        if (rst_n) begin
            vecs++;
            if (((req_ready & ~(NREQ'(1) << grant_id)) != 0) || (tx_busy && req_ready != 0)) begin
                miscmp++;
                $display("FAIL ready_rule ready=%b grant=%0d busy=%b", req_ready, grant_id, tx_busy);
            end
            if (tx_write) begin
                vecs++;
                if (tx_busy) begin
                    miscmp++;
                    $display("FAIL write_while_busy at cycle %0d", cyc);
                end
                got_id.push_back(int'(grant_id));
                got_byte.push_back(tx_data);
            end else begin
                vecs++;
                if (tx_data !== prev_data) begin
                    miscmp++;
                    $display("FAIL data_hold got %02h want %02h", tx_data, prev_data);
                end
            end
        end
        prev_data = tx_data;
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++)
            if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        if (s_write && rst_n && !tx_dead) tx_left = int'($urandom_range(busy_max, busy_min));
        if (tx_left > 0) begin
            tx_busy = 1'b1;
            tx_left--;
        end else begin
            tx_busy = 1'b0;
        end
        drive_reqs();
    endtask

    task automatic run_idle(input int max_cyc);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            step();
            n++;
            done = !s_busy && !s_active && !s_write && tx_left == 0;
            for (int k = 0; k < NREQ; k++) if (rq[k].size() > 0) done = 1'b0;
        end
        vecs++;
        if (!done) begin
            miscmp++;
            $display("FAIL run_idle no idle after %0d cycles", max_cyc);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        tx_busy = 1'b0;
        tx_left = 0;
        tx_dead = 1'b0;
        busy_min = 4;
        busy_max = 4;
        m_ptr = 0;
        for (int k = 0; k < NREQ; k++) rq[k].delete();
        got_id.delete();
        got_byte.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_data = 8'hff;
    endtask

    // Packet-level round robin: whole packets, lowest queue at or after the pointer.
    task automatic model_expect();
        logic [8:0] mq [NREQ][$];
        logic [8:0] b;
        int  k;
        bit  found;
        for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
        exp_id.delete();
        exp_byte.delete();
        while (1) begin
            found = 1'b0;
            k = 0;
            for (int off = 0; off < NREQ; off++) begin
                if (!found && mq[(m_ptr + off) % NREQ].size() > 0) begin
                    k = (m_ptr + off) % NREQ;
                    found = 1'b1;
                end
            end
            if (!found) break;
            do begin
                b = mq[k].pop_front();
                exp_id.push_back(k);
                exp_byte.push_back(b[7:0]);
            end while (!b[8] && mq[k].size() > 0);
            m_ptr = (k + 1) % NREQ;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        vecs += 6;
        if (tx_write !== 1'b0) begin miscmp++; $display("FAIL reset_write got %b want 0", tx_write); end
        if (tx_data !== 8'hff) begin miscmp++; $display("FAIL reset_data got %02h want ff", tx_data); end
        if (req_ready !== '0) begin miscmp++; $display("FAIL reset_ready got %b want 0", req_ready); end
        if (err !== 1'b0) begin miscmp++; $display("FAIL reset_err got %b want 0", err); end
        if (active !== 1'b0) begin miscmp++; $display("FAIL reset_active got %b want 0", active); end
        if (grant_id !== '0) begin miscmp++; $display("FAIL reset_grant got %0d want 0", grant_id); end
    endtask

    task automatic test_single();
        apply_reset();
        rq[0].push_back({1'b1, 8'h48});
        model_expect();
        run_idle(200);
        vecs += 2;
        if (got_id.size() !== 1) begin miscmp++; $display("FAIL single_count got %0d want 1", got_id.size()); end
        else if (got_byte[0] !== 8'h48 || got_id[0] !== 0) begin
            miscmp++; $display("FAIL single_byte got id%0d/%02h want id0/48", got_id[0], got_byte[0]);
        end
        if (s_active !== 1'b0) begin miscmp++; $display("FAIL single_release active got %b want 0", s_active); end
        // Pointer now sits at 1, so requester 1 wins over requester 0.
        got_id.delete();
        got_byte.delete();
        rq[0].push_back({1'b1, 8'h41});
        rq[1].push_back({1'b1, 8'h42});
        model_expect();
        run_idle(300);
        vecs++;
        if (got_id.size() !== exp_id.size()) begin miscmp++; $display("FAIL single_ptr_count got %0d want %0d", got_id.size(), exp_id.size()); end
        for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
            vecs++;
            if (got_id[i] !== exp_id[i] || got_byte[i] !== exp_byte[i]) begin
                miscmp++; $display("FAIL single_ptr[%0d] got id%0d/%02h want id%0d/%02h", i, got_id[i], got_byte[i], exp_id[i], exp_byte[i]);
            end
        end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NREQ; k++) rq[k].push_back({1'b1, 8'(8'h30 + 16*r + k)});
        model_expect();
        run_idle(600);
        vecs++;
        if (got_id.size() !== exp_id.size()) begin miscmp++; $display("FAIL contention_count got %0d want %0d", got_id.size(), exp_id.size()); end
        for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
            vecs++;
            if (got_id[i] !== exp_id[i] || got_byte[i] !== exp_byte[i]) begin
                miscmp++; $display("FAIL contention[%0d] got id%0d/%02h want id%0d/%02h", i, got_id[i], got_byte[i], exp_id[i], exp_byte[i]);
            end
        end
    endtask

    task automatic test_packet_lock();
        apply_reset();
        rq[2].push_back({1'b0, 8'h48});
        rq[2].push_back({1'b1, 8'h65});
        rq[3].push_back({1'b1, 8'h21});
        model_expect();
        run_idle(300);
        vecs++;
        if (got_id.size() !== 3) begin miscmp++; $display("FAIL lock_count got %0d want 3", got_id.size()); end
        for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
            vecs++;
            if (got_id[i] !== exp_id[i] || got_byte[i] !== exp_byte[i]) begin
                miscmp++; $display("FAIL lock[%0d] got id%0d/%02h want id%0d/%02h", i, got_id[i], got_byte[i], exp_id[i], exp_byte[i]);
            end
        end
    endtask

    task automatic test_stall_timeout();
        int  held;
        int  n;
        bit  seen_busy;
        bit  pushed;
        int  want_id[3];
        logic [7:0] want_byte[3];
        apply_reset();
        rq[1].push_back({1'b0, 8'h48});
        rq[2].push_back({1'b1, 8'h32});
        held = 0;
        n = 0;
        seen_busy = 1'b0;
        pushed = 1'b0;
        while (n < 300 && !(seen_busy && !s_active && got_id.size() > 0)) begin
            step();
            n++;
            if (got_id.size() == 1 && s_busy) seen_busy = 1'b1;
            if (seen_busy && got_id.size() == 1 && !s_busy && s_active) held++;
            // Requester 0 shows up during the stall; it must not be granted ahead of requester 2.
            if (held == 3 && !pushed) begin
                rq[0].push_back({1'b1, 8'h30});
                pushed = 1'b1;
                drive_reqs();
            end
        end
        // One cycle to see the transmitter finish, then HOLD idle cycles in the issue phase.
        vecs++;
        if (held !== HOLD + 1) begin miscmp++; $display("FAIL stall_hold got %0d want %0d", held, HOLD + 1); end
        run_idle(300);
        want_id = '{1, 2, 0};
        want_byte = '{8'h48, 8'h32, 8'h30};
        vecs++;
        if (got_id.size() !== 3) begin miscmp++; $display("FAIL stall_count got %0d want 3", got_id.size()); end
        for (int i = 0; i < got_id.size() && i < 3; i++) begin
            vecs++;
            if (got_id[i] !== want_id[i] || got_byte[i] !== want_byte[i]) begin
                miscmp++; $display("FAIL stall[%0d] got id%0d/%02h want id%0d/%02h", i, got_id[i], got_byte[i], want_id[i], want_byte[i]);
            end
        end
    endtask

    task automatic test_dead_tx();
        bit   seen;
        int   n;
        logic e[3];
        apply_reset();
        tx_dead = 1'b1;
        rq[3].push_back({1'b1, 8'h5a});
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            step();
            n++;
            seen = s_write;
        end
        vecs++;
        if (!seen) begin miscmp++; $display("FAIL dead_strobe no write within 100 cycles"); end
        for (int i = 0; i < 3; i++) begin
            step();
            e[i] = s_err;
        end
        vecs += 3;
        if (e[0] !== 1'b0) begin miscmp++; $display("FAIL dead_err_t1 got %b want 0", e[0]); end
        if (e[1] !== 1'b0) begin miscmp++; $display("FAIL dead_err_t2 got %b want 0", e[1]); end
        if (e[2] !== 1'b1) begin miscmp++; $display("FAIL dead_err_t3 got %b want 1", e[2]); end
        rq[0].push_back({1'b1, 8'h11});
        run_idle(200);
        vecs += 2;
        if (got_id.size() !== 2 || got_byte[got_byte.size()-1] !== 8'h11) begin
            miscmp++; $display("FAIL dead_continue writes=%0d want 2 ending in 11", got_id.size());
        end
        if (s_err !== 1'b1) begin miscmp++; $display("FAIL dead_sticky got %b want 1", s_err); end
    endtask

    task automatic test_reset_mid();
        int n;
        int busy_cycles;
        apply_reset();
        busy_min = 8;
        busy_max = 8;
        rq[2].push_back({1'b0, 8'h61});
        rq[2].push_back({1'b0, 8'h62});
        rq[2].push_back({1'b1, 8'h63});
        n = 0;
        busy_cycles = 0;
        while (n < 100 && busy_cycles < 2) begin
            step();
            n++;
            if (got_id.size() == 1 && s_busy) busy_cycles++;
        end
        vecs++;
        if (busy_cycles < 2) begin miscmp++; $display("FAIL midrst_setup busy cycles %0d want 2", busy_cycles); end
        #2;
        rst_n = 1'b0;
        #1;
        vecs += 6;
        if (tx_write !== 1'b0) begin miscmp++; $display("FAIL midrst_write got %b want 0", tx_write); end
        if (tx_data !== 8'hff) begin miscmp++; $display("FAIL midrst_data got %02h want ff", tx_data); end
        if (req_ready !== '0) begin miscmp++; $display("FAIL midrst_ready got %b want 0", req_ready); end
        if (err !== 1'b0) begin miscmp++; $display("FAIL midrst_err got %b want 0", err); end
        if (active !== 1'b0) begin miscmp++; $display("FAIL midrst_active got %b want 0", active); end
        if (grant_id !== '0) begin miscmp++; $display("FAIL midrst_grant got %0d want 0", grant_id); end
        for (int k = 0; k < NREQ; k++) rq[k].delete();
        tx_left = 0;
        tx_busy = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++;
            if (s_write !== 1'b0) begin miscmp++; $display("FAIL midrst_strobe got %b want 0", s_write); end
        end
        rq[1].push_back({1'b1, 8'h71});
        rq[3].push_back({1'b1, 8'h73});
        drive_reqs();
        got_id.delete();
        got_byte.delete();
        rst_n = 1'b1;
        prev_data = 8'hff;
        run_idle(300);
        vecs++;
        if (got_id.size() !== 2 || got_id[0] !== 1 || got_id[1] !== 3) begin
            miscmp++; $display("FAIL midrst_regrant writes=%0d first=%0d want 2 writes 1 then 3",
                               got_id.size(), (got_id.size() > 0) ? got_id[0] : -1);
        end
    endtask

    task automatic test_random();
        int npk;
        int len;
        apply_reset();
        busy_min = 1;
        busy_max = 6;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NREQ; k++) begin
                npk = int'($urandom_range(3, 0));
                for (int p = 0; p < npk; p++) begin
                    len = int'($urandom_range(4, 1));
                    for (int b = 0; b < len; b++)
                        rq[k].push_back({(b == len - 1), 8'($urandom)});
                end
            end
            model_expect();
            got_id.delete();
            got_byte.delete();
            run_idle(3000);
            vecs++;
            if (got_id.size() !== exp_id.size()) begin
                miscmp++; $display("FAIL random_count round %0d got %0d want %0d", r, got_id.size(), exp_id.size());
            end
            for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
                vecs++;
                if (got_id[i] !== exp_id[i] || got_byte[i] !== exp_byte[i]) begin
                    miscmp++; $display("FAIL random[%0d.%0d] got id%0d/%02h want id%0d/%02h", r, i, got_id[i], got_byte[i], exp_id[i], exp_byte[i]);
                end
            end
        end
    endtask

    initial begin
        vecs = 0;
        miscmp = 0;
        cyc = 0;
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        tx_busy = 1'b0;
        prev_data = 8'hff;
        test_reset();
        test_single();
        test_contention();
        test_packet_lock();
        test_stall_timeout();
        test_dead_tx();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter HOLD_TIMEOUT, default 16, idle cycles before a held packet grant is revoked.
REQ-003 SHALL have port i_uart_clk  in  1  sole clock, same clock as the UART transmitter.
REQ-004 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_req_valid  in  NREQ  per-requester byte valid.
REQ-006 SHALL have port i_req_data  in  8*NREQ  per-requester byte; requester k uses bits [8k+7:8k].
REQ-007 SHALL have port i_req_last  in  NREQ  byte is last of packet.
REQ-008 SHALL have port o_req_ready  out  NREQ  byte accepted when valid&ready.
REQ-009 SHALL have port o_tx_write  out  1  write strobe to transmitter.
REQ-010 SHALL have port o_tx_data  out  8  byte to transmitter.
REQ-011 SHALL have port i_tx_busy  in  1  transmitter busy.
REQ-012 SHALL have port o_grant_id  out  $clog2(NREQ)  current owner.
REQ-013 SHALL have port o_active  out  1  a grant is held.
REQ-014 SHALL have port o_err  out  1  sticky: transmitter failed to acknowledge a write.

Function
REQ-015 SHALL implement states ARB, ISSUE, WRITE, WAIT_ACK, WAIT_DONE.
REQ-016 ARB: SHALL grant the first valid requester at or after the round-robin pointer, wrapping, and go to ISSUE; with no valid requester it SHALL stay in ARB with o_active=0.
REQ-017 ISSUE: SHALL drive o_req_ready[grant]=1 only while i_tx_busy=0; all other ready bits SHALL be 0 in every state.
REQ-018 On accept, SHALL register the byte into o_tx_data, latch last, and assert o_tx_write for exactly one cycle (state WRITE), one cycle after accept.
REQ-019 WAIT_ACK: SHALL wait for i_tx_busy=1; if it is not seen within 2 cycles after the write strobe, SHALL set o_err and go to WAIT_DONE.
REQ-020 WAIT_DONE: SHALL wait for i_tx_busy=0; then SHALL go to ARB if last was latched, else to ISSUE.
REQ-021 On leaving the packet (last byte done or timeout), SHALL set the pointer to grant+1 modulo NREQ.
REQ-022 In ISSUE with the granted valid low, SHALL count idle cycles; on reaching HOLD_TIMEOUT, SHALL release the grant (go to ARB, advance the pointer); the counter SHALL clear on any accept.
REQ-023 A requester SHALL never be preempted mid-packet except by REQ-022.
REQ-024 Valid changes on non-granted requesters SHALL have no effect until ARB.
REQ-025 Throughput: SHALL never issue a second write before i_tx_busy has returned to 0 after the previous one.
REQ-026 o_tx_data SHALL hold its value outside the WRITE state.

Reset
REQ-027 On i_rst_n=0, SHALL asynchronously set state to ARB, pointer to 0, o_grant_id to 0, o_active to 0, o_tx_write to 0, o_tx_data to 8'hff, o_req_ready to 0, o_err to 0, and the timeout counter to 0.
REQ-028 Reset mid-packet SHALL abandon the packet with no further write strobes; o_tx_write SHALL be 0 from reset assertion.

Structure
REQ-029 Shared package SHALL hold the state encoding and the ACK window constant (2).
REQ-030 The round-robin pick SHALL be a sub-module rr_pick (mask, pointer -> index, found), combinational.
REQ-031 The implementation SHALL instantiate no transmitter; the bench pairs it with uart_tx.

Verification
REQ-032 Single request: requester 0 sends 8'h48 with last=1 -> one strobe carrying 8'h48, grant released, pointer=1.
REQ-033 Contention: all four requesters send single-byte packets at once -> write order 0,1,2,3, then repeats from 0.
REQ-034 Packet lock: requester 2 sends "He" (8'h48, 8'h65 with last=1) while requester 3 is valid -> both bytes before any byte from requester 3.
REQ-035 Stall timeout: requester 1 sends a non-last byte then drops valid -> grant released after 16 idle cycles; requester 2 is granted next.
REQ-036 Dead transmitter: i_tx_busy tied to 0 -> o_err=1 three cycles after the strobe; the arbiter continues.
REQ-037 Reset during WAIT_DONE -> all outputs at their reset values immediately; next grant goes to the lowest valid requester.
